// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the three sides of the shared memory port: the fetch requester
//   (if_*), the data-stage requester (d_*), and the single-ported memory
//   (mem_*). The starvation counter is exposed here for debug visibility.
//
//   Modports:
//     slave  - the arbiter: takes requests and memory read data, and drives
//              grants, responses and the memory control signals.
//     master - the environment, meaning the pipeline stages and the memory.
//
//   ADDR_W is the word-index width of the shared memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 6
);
    // fetch side
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_stall;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              if_err;

    // data side
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;

    // memory side
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // debug
    logic [1:0]        starve_cnt;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  mem_rdata,
        output if_gnt, if_stall, if_rvalid, if_rdata, if_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_addr, mem_we, mem_be, mem_wdata,
        output starve_cnt
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output mem_rdata,
        input  if_gnt, if_stall, if_rvalid, if_rdata, if_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_addr, mem_we, mem_be, mem_wdata,
        input  starve_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single-ported memory between the fetch stage and the data-memory
//   stage. The memory has combinational read and synchronous write. Each
//   cycle at most one requester is granted, and the grant is combinational.
//   Read data is registered and comes back one cycle after the grant.
//   Normally the data stage wins a conflict. Once fetch has been denied
//   MAX_STARVE cycles in a row, fetch wins the next conflict instead.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-low reset
//     bus  - mem_port_arbiter_if.slave, which carries the fetch and data
//            request/response channels, the memory port, and the starve_cnt
//            debug counter
module mem_port_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int MAX_STARVE = 3
) (
    input logic                  clk,
    input logic                  rst,
    mem_port_arbiter_if.slave    bus
);

    localparam logic [1:0] STARVE_LIMIT = 2'(MAX_STARVE);

    logic        if_gnt;
    logic        d_gnt;
    logic        if_fault;
    logic        d_fault;
    logic [31:0] sel_addr;
    logic [1:0]  starve_cnt;

    logic        if_rvalid_q;
    logic        if_err_q;
    logic [31:0] if_rdata_q;
    logic        d_rvalid_q;
    logic        d_err_q;
    logic [31:0] d_rdata_q;

    // An address faults if it is misaligned or points past the last word.
    function automatic logic addr_fault(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);
    endfunction

    assign if_fault = addr_fault(bus.if_addr);
    assign d_fault  = addr_fault(bus.d_addr);

    // Grants are held low while reset is asserted, so no write can reach the
    // memory during reset.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first. Otherwise a path that skips the assignment infers a latch.
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst) begin
            if (bus.if_req && bus.d_req) begin
                if (starve_cnt == STARVE_LIMIT) begin
                    if_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
            end else begin
                if_gnt = bus.if_req;
                d_gnt  = bus.d_req;
            end
        end
    end

    // When the data stage is not granted, the memory sees the fetch address.
    // This also covers the idle case.
    assign sel_addr      = d_gnt ? bus.d_addr : bus.if_addr;
    assign bus.mem_addr  = sel_addr[ADDR_W+1:2];
    assign bus.mem_we    = d_gnt & bus.d_we & ~d_fault;
    assign bus.mem_be    = bus.d_be;
    assign bus.mem_wdata = bus.d_wdata;

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_stall  = bus.if_req & ~if_gnt;

    // The counter counts consecutive cycles in which fetch wants the port
    // and is denied. It saturates at the limit. A fetch grant clears it, and
    // so does a cycle where fetch is not requesting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 2'd0;
        end else if (!bus.if_req || if_gnt) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples values from before the edge.
            starve_cnt <= 2'd0;
        end else if (starve_cnt != STARVE_LIMIT) begin
            starve_cnt <= starve_cnt + 2'd1;
        end
    end

    assign bus.starve_cnt = starve_cnt;

    // Response registers. The rvalid and err flags follow the grant and last
    // exactly one cycle. The rdata registers load only on a grant and hold
    // their value otherwise. Faults and writes return zero data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= 32'd0;
        end else begin
            if_rvalid_q <= if_gnt;
            if_err_q    <= if_gnt & if_fault;
            d_rvalid_q  <= d_gnt;
            d_err_q     <= d_gnt & d_fault;
            if (if_gnt) begin
                if_rdata_q <= if_fault ? 32'd0 : bus.mem_rdata;
            end
            if (d_gnt) begin
                d_rdata_q <= (d_fault || bus.d_we) ? 32'd0 : bus.mem_rdata;
            end
        end
    end

    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_err    = if_err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_err     = d_err_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed testbench for mem_port_arbiter. It includes a 64-word
//   behavioural memory model. Word i is preloaded with 32'h1000_0000 + i.
//   Inputs change on the falling edge. Combinational outputs are sampled
//   1 ns after that edge, and registered outputs on the following falling
//   edge.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 6;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [64];

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_STARVE(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: combinational read, byte-enabled synchronous write.
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.if_req  = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_be    = 4'h0;
        bus.if_addr = 32'd0;
        bus.d_addr  = 32'd0;
        bus.d_wdata = 32'd0;
    endtask

    task automatic drive_d(input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_be    = be;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;

        // Reset held, with both requesters active and a write pending.
        rst = 1'b0;
        idle();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h8;
        drive_d(1'b1, 4'hF, 32'h0, 32'hFFFF_FFFF);
        #2;
        check("rst_if_gnt",   bus.if_gnt,     0);
        check("rst_d_gnt",    bus.d_gnt,      0);
        check("rst_mem_we",   bus.mem_we,     0);
        check("rst_if_rval",  bus.if_rvalid,  0);
        check("rst_d_rval",   bus.d_rvalid,   0);
        check("rst_if_err",   bus.if_err,     0);
        check("rst_d_err",    bus.d_err,      0);
        check("rst_if_rdata", bus.if_rdata,   0);
        check("rst_d_rdata",  bus.d_rdata,    0);
        @(negedge clk);
        check("rst_starve",   bus.starve_cnt, 0);
        check("rst_mem0",     mem[0],         32'h1000_0000);
        idle();
        rst = 1'b1;

        // 1. Fetch only from 0x8, which is word 2.
        bus.if_req = 1'b1;
        bus.if_addr = 32'h8;
        #1;
        check("t1_if_gnt",   bus.if_gnt,   1);
        check("t1_d_gnt",    bus.d_gnt,    0);
        check("t1_mem_addr", bus.mem_addr, 2);
        check("t1_stall",    bus.if_stall, 0);
        @(negedge clk);
        idle();
        check("t1_if_rval",  bus.if_rvalid, 1);
        check("t1_if_rdata", bus.if_rdata,  32'h1000_0002);
        check("t1_if_err",   bus.if_err,    0);
        check("t1_d_rval",   bus.d_rvalid,  0);
        #1;
        check("t1_idle_addr", bus.mem_addr, 0);
        @(negedge clk);
        check("t1_rval_drop", bus.if_rvalid, 0);
        check("t1_rdata_hold", bus.if_rdata, 32'h1000_0002);

        // 2. Write, then read-after-write, then a partial write and a read.
        drive_d(1'b1, 4'hF, 32'hC, 32'hDEAD_BEEF);
        #1;
        check("t2_d_gnt",    bus.d_gnt,    1);
        check("t2_mem_we",   bus.mem_we,   1);
        check("t2_mem_addr", bus.mem_addr, 3);
        check("t2_mem_be",   bus.mem_be,   4'hF);
        @(negedge clk);
        check("t2_wr_rval",  bus.d_rvalid, 1);
        check("t2_wr_rdata", bus.d_rdata,  0);
        check("t2_wr_err",   bus.d_err,    0);
        drive_d(1'b0, 4'hF, 32'hC, 32'h0);
        #1;
        check("t2_rd_we",    bus.mem_we,   0);
        @(negedge clk);
        check("t2_rd_rval",  bus.d_rvalid, 1);
        check("t2_rd_rdata", bus.d_rdata,  32'hDEAD_BEEF);
        drive_d(1'b1, 4'h3, 32'hC, 32'h1234_5678);
        @(negedge clk);
        drive_d(1'b0, 4'hF, 32'hC, 32'h0);
        @(negedge clk);
        check("t2_be_rdata", bus.d_rdata,  32'hDEAD_5678);
        idle();
        @(negedge clk);

        // 3. Both requesters active continuously: data gets three grants,
        //    then fetch is forced through.
        bus.if_req = 1'b1;
        bus.if_addr = 32'h10;
        drive_d(1'b0, 4'hF, 32'h14, 32'h0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                check("t3_d_rval",  bus.d_rvalid,  ((k - 1) % 4 != 3) ? 1 : 0);
                check("t3_if_rval", bus.if_rvalid, ((k - 1) % 4 == 3) ? 1 : 0);
                if ((k - 1) % 4 != 3) check("t3_d_rdata", bus.d_rdata, 32'h1000_0005);
                else                  check("t3_if_rdata", bus.if_rdata, 32'h1000_0004);
            end
            #1;
            check("t3_starve",   bus.starve_cnt, k % 4);
            check("t3_d_gnt",    bus.d_gnt,      (k % 4 != 3) ? 1 : 0);
            check("t3_if_gnt",   bus.if_gnt,     (k % 4 == 3) ? 1 : 0);
            check("t3_stall",    bus.if_stall,   (k % 4 != 3) ? 1 : 0);
            check("t3_mem_addr", bus.mem_addr,   (k % 4 != 3) ? 5 : 4);
            @(negedge clk);
        end
        check("t3_end_starve", bus.starve_cnt, 0);
        check("t3_end_if_rval", bus.if_rvalid, 1);
        check("t3_end_if_rdata", bus.if_rdata, 32'h1000_0004);
        // When fetch drops its request, the count clears.
        @(negedge clk);
        @(negedge clk);
        check("t3_cnt_two", bus.starve_cnt, 2);
        bus.if_req = 1'b0;
        @(negedge clk);
        check("t3_cnt_clear", bus.starve_cnt, 0);
        idle();
        @(negedge clk);

        // 4. A misaligned write is granted, does not write, and reports an error.
        drive_d(1'b1, 4'hF, 32'h102, 32'hCAFE_F00D);
        #1;
        check("t4_d_gnt",  bus.d_gnt,  1);
        check("t4_mem_we", bus.mem_we, 0);
        @(negedge clk);
        check("t4_rval",   bus.d_rvalid, 1);
        check("t4_err",    bus.d_err,    1);
        check("t4_rdata",  bus.d_rdata,  0);
        drive_d(1'b0, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        check("t4_mem0",   bus.d_rdata,  32'h1000_0000);
        check("t4_mem0_err", bus.d_err,  0);
        idle();

        // 5. The last valid word, then an out-of-range fetch.
        bus.if_req = 1'b1;
        bus.if_addr = 32'hFC;
        @(negedge clk);
        check("t5_last_err",   bus.if_err,   0);
        check("t5_last_rdata", bus.if_rdata, 32'h1000_003F);
        bus.if_addr = 32'h100;
        #1;
        check("t5_oor_gnt",    bus.if_gnt,   1);
        @(negedge clk);
        idle();
        check("t5_oor_rval",   bus.if_rvalid, 1);
        check("t5_oor_err",    bus.if_err,    1);
        check("t5_oor_rdata",  bus.if_rdata,  0);

        // 6. Reset asserted in the cycle after a grant.
        bus.if_req = 1'b1;
        bus.if_addr = 32'h10;
        drive_d(1'b0, 4'hF, 32'h14, 32'h0);
        @(negedge clk);
        check("t6_pre_rval",   bus.d_rvalid,   1);
        check("t6_pre_starve", bus.starve_cnt, 1);
        bus.d_we = 1'b1;
        rst = 1'b0;
        #1;
        check("t6_rval",   bus.d_rvalid,   0);
        check("t6_err",    bus.d_err,      0);
        check("t6_starve", bus.starve_cnt, 0);
        check("t6_rdata",  bus.d_rdata,    0);
        check("t6_d_gnt",  bus.d_gnt,      0);
        check("t6_if_gnt", bus.if_gnt,     0);
        check("t6_mem_we", bus.mem_we,     0);
        @(negedge clk);
        idle();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t6_post_d_rval",  bus.d_rvalid,  0);
            check("t6_post_if_rval", bus.if_rvalid, 0);
        end
        check("t6_mem5", mem[5], 32'h1000_0005);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
